// File: rtl/text_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : text_video_pkg
// Purpose  : Shared constants and helpers for the text-mode video path:
//            RGB444 width, font cell geometry, font ROM address width,
//            default screen geometry and default colours.
// Revision : 1.0 - initial release
// ============================================================================
package text_video_pkg;

    localparam int c_RGB_W      = 12;
    localparam int c_FONT_W     = 8;
    localparam int c_FONT_H     = 8;
    localparam int c_ROM_ADDR_W = 10;
    localparam int c_DEF_COLS   = 80;
    localparam int c_DEF_ROWS   = 60;

    typedef logic [c_RGB_W-1:0] rgb_t;

    localparam rgb_t c_FG_WHITE = 12'hFFF;
    localparam rgb_t c_BG_BLACK = 12'h000;

    // Row base address for an 80-column screen: r*80 = (r<<6) + (r<<4).
    // 127*80 + 127 fits in 14 bits, so the sum never overflows here.
    function automatic logic [13:0] mul80(input logic [6:0] r);
        return {1'b0, r, 6'b0} + {3'b0, r, 4'b0};
    endfunction

endpackage : text_video_pkg
`default_nettype wire

// File: rtl/cursor_blink.sv
`default_nettype none
// ============================================================================
// Module   : cursor_blink
// Purpose  : Counts frames on the falling edge of vsync and toggles the
//            cursor blink phase every BLINK_FRAMES frames. Only built when
//            TEXT_CURSOR_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cursor_blink #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    output logic o_blink_on
);

    localparam int c_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_FRAMES - 1);

    logic               r_vsync_d;
    logic [c_CNT_W-1:0] r_frame_cnt;
    logic               r_blink_on;
    logic               w_frame_start;

    // A new frame starts where vsync drops (sync is active-low).
    assign w_frame_start = r_vsync_d & ~i_vsync;

    // Edge detector, frame counter and blink phase toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d   <= 1'b0;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            if (w_frame_start) begin
                if (r_frame_cnt == c_CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign o_blink_on = r_blink_on;

endmodule : cursor_blink
`default_nettype wire

// File: rtl/text_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : text_pixel_gen
// Purpose  : Text-mode pixel generator. Turns timing-generator coordinates
//            into text buffer and font ROM addresses, serialises the glyph
//            row into RGB444 pixels and delays the syncs to match.
//            Pipeline: S0 address calc -> S1 (buffer read) -> S2 (font ROM,
//            combinational) -> S3 output register; latency 3 cycles.
//            Optional blinking cursor: define TEXT_CURSOR_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module text_pixel_gen
    import text_video_pkg::*;
#(
    parameter int   COLS         = c_DEF_COLS,
    parameter int   ROWS         = c_DEF_ROWS,
    parameter int   TXT_AW       = 13,
    parameter rgb_t FG_COLOR     = c_FG_WHITE,
    parameter rgb_t BG_COLOR     = c_BG_BLACK,
    parameter int   BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic                    video_on,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    output logic [TXT_AW-1:0]       txt_addr,
    input  logic [7:0]              txt_char,
    output logic [c_ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]              rom_data,
    input  logic [6:0]              cursor_col,
    input  logic [5:0]              cursor_row,
    output logic [c_RGB_W-1:0]      rgb,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    video_on_out
);

    localparam int          c_XSUB_W = $clog2(c_FONT_W);
    localparam int          c_YSUB_W = $clog2(c_FONT_H);
    localparam logic [31:0] c_CELLS  = 32'(COLS * ROWS);

    // ---------------- S0: address calculation ----------------
    logic [6:0]        w_cell_col;
    logic [6:0]        w_cell_row;
    logic [31:0]       w_row_base;
    logic [TXT_AW-1:0] w_txt_addr;

    assign w_cell_col = pixel_x[9:3];
    assign w_cell_row = pixel_y[9:3];

    generate
        if (COLS == 80) begin : g_mul80
            assign w_row_base = 32'(mul80(w_cell_row));
        end else begin : g_mul_gen
            assign w_row_base = 32'(w_cell_row) * 32'(COLS);
        end
    endgenerate

    // Out-of-range rows/columns simply wrap into the buffer's address space.
    assign w_txt_addr = TXT_AW'(w_row_base + 32'(w_cell_col));

    // ---------------- S1 / S2 pipeline registers ----------------
    logic [TXT_AW-1:0]   r_txt_addr;
    logic [c_XSUB_W-1:0] r_xsub1, r_xsub2;
    logic [c_YSUB_W-1:0] r_ysub1, r_ysub2;
    logic                r_von1, r_von2;
    logic                r_hs1, r_hs2;
    logic                r_vs1, r_vs2;
    logic [6:0]          r_col1, r_col2;
    logic [6:0]          r_row1, r_row2;

    // Carry coordinates and timing alongside the buffer read; syncs idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txt_addr <= '0;
            r_xsub1    <= '0;
            r_ysub1    <= '0;
            r_von1     <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_col1     <= '0;
            r_row1     <= '0;
            r_xsub2    <= '0;
            r_ysub2    <= '0;
            r_von2     <= 1'b0;
            r_hs2      <= 1'b1;
            r_vs2      <= 1'b1;
            r_col2     <= '0;
            r_row2     <= '0;
        end else begin
            r_txt_addr <= w_txt_addr;
            r_xsub1    <= pixel_x[c_XSUB_W-1:0];
            r_ysub1    <= pixel_y[c_YSUB_W-1:0];
            r_von1     <= video_on;
            r_hs1      <= hsync_in;
            r_vs1      <= vsync_in;
            r_col1     <= w_cell_col;
            r_row1     <= w_cell_row;
            r_xsub2    <= r_xsub1;
            r_ysub2    <= r_ysub1;
            r_von2     <= r_von1;
            r_hs2      <= r_hs1;
            r_vs2      <= r_vs1;
            r_col2     <= r_col1;
            r_row2     <= r_row1;
        end
    end

    assign txt_addr = r_txt_addr;

    // ---------------- S2: font lookup and cursor ----------------
    assign rom_addr = {txt_char[6:0], r_ysub2};

    logic w_cursor_hit;

`ifdef TEXT_CURSOR_BLINK_EN
    logic w_blink_on;

    cursor_blink #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cursor_blink (
        .clk        (clk),
        .rst        (reset),
        .i_vsync    (vsync_in),
        .o_blink_on (w_blink_on)
    );

    assign w_cursor_hit = w_blink_on
                        && (r_col2 == cursor_col)
                        && (r_row2 == {1'b0, cursor_row});
`else
    logic w_unused_cursor;

    assign w_cursor_hit    = 1'b0;
    assign w_unused_cursor = &{1'b0, cursor_col, cursor_row, r_col2, r_row2,
                               BLINK_FRAMES[0]};
`endif

    // Screen size is informational only; the buffer handles out-of-range reads.
    logic w_unused_cfg;
    assign w_unused_cfg = ^c_CELLS;

    // ---------------- S3: pixel select and output register ----------------
    // The glyph row, inverse attribute and cursor flag are consumed straight
    // from S2 so that the output register is the third and last stage.
    logic [c_XSUB_W-1:0] w_bit_idx;
    logic                w_bit;

    assign w_bit_idx = c_XSUB_W'(c_FONT_W - 1) - r_xsub2;
    assign w_bit     = rom_data[w_bit_idx] ^ (txt_char[7] | w_cursor_hit);

    rgb_t r_rgb;
    logic r_hs3, r_vs3, r_von3;

    // Output register: pixel colour, blanked outside the active area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb  <= '0;
            r_hs3  <= 1'b1;
            r_vs3  <= 1'b1;
            r_von3 <= 1'b0;
        end else begin
            r_rgb  <= r_von2 ? (w_bit ? FG_COLOR : BG_COLOR) : rgb_t'(0);
            r_hs3  <= r_hs2;
            r_vs3  <= r_vs2;
            r_von3 <= r_von2;
        end
    end

    assign rgb          = r_rgb;
    assign hsync_out    = r_hs3;
    assign vsync_out    = r_vs3;
    assign video_on_out = r_von3;

endmodule : text_pixel_gen
`default_nettype wire

// File: tb/tb_text_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_pixel_gen
// Purpose  : Directed self-checking bench for text_pixel_gen. Models the
//            synchronous text buffer; drives the font ROM data directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_pixel_gen;

`ifdef TEXT_CURSOR_BLINK_EN
    localparam bit c_BLINK_BUILD = 1'b1;
`else
    localparam bit c_BLINK_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync_in, vsync_in;
    logic [12:0] txt_addr;
    logic [7:0]  txt_char = 8'h00;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, video_on_out;

    logic [7:0]  mem [0:8191];
    logic [11:0] want [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Text buffer: synchronous read, one cycle latency.
    always @(posedge clk) txt_char <= mem[txt_addr];

    text_pixel_gen #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .txt_addr     (txt_addr),
        .txt_char     (txt_char),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .rgb          (rgb),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    // Drive npix consecutive pixels from x0 on line y and check rgb against want[].
    task automatic scan(input logic [9:0] x0, input logic [9:0] y, input int npix, input string tag);
        for (int i = 0; i < npix + 2; i++) begin
            if (i < npix) pixel_x = x0 + 10'(i);
            pixel_y  = y;
            video_on = 1'b1;
            step();
            if (i >= 2) chk($sformatf("%s[%0d]", tag, i - 2), 32'(rgb), 32'(want[i - 2]));
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 8'h20;
        reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; rom_data = 8'h00;
        cursor_col = 7'd1; cursor_row = 6'd0;
        step(); step();

        chk("rst_rgb",   32'(rgb), 32'h000);
        chk("rst_hs",    32'(hsync_out), 32'd1);
        chk("rst_vs",    32'(vsync_out), 32'd1);
        chk("rst_von",   32'(video_on_out), 32'd0);
        chk("rst_taddr", 32'(txt_addr), 32'd0);
        reset = 1'b0;

        // Address generation and font ROM address
        mem[82] = 8'h41;
        pixel_x = 10'd16; pixel_y = 10'd8; video_on = 1'b1;
        step();
        chk("taddr_82", 32'(txt_addr), 32'd82);
        step();
        chk("rom_520", 32'(rom_addr), 32'd520);
        pixel_y = 10'd13;
        step(); step();
        chk("rom_525", 32'(rom_addr), 32'd525);
        pixel_x = 10'd639; pixel_y = 10'd479;
        step();
        chk("taddr_4799", 32'(txt_addr), 32'd4799);
        pixel_x = 10'd632; pixel_y = 10'd0;
        step();
        chk("taddr_79", 32'(txt_addr), 32'd79);
        pixel_x = 10'd1023; pixel_y = 10'd1023;
        step();
        chk("taddr_wrap", 32'(txt_addr), 32'd2095);

        // Glyph 1000_0001, plain 'A'
        mem[0] = 8'h41; rom_data = 8'b1000_0001;
        want = '{default: 12'h000};
        want[0] = 12'hFFF; want[7] = 12'hFFF;
        scan(10'd0, 10'd0, 8, "glyph81");

        // Same glyph, inverse 'A'
        mem[0] = 8'hC1;
        want = '{default: 12'hFFF};
        want[0] = 12'h000; want[7] = 12'h000;
        scan(10'd0, 10'd0, 8, "inv81");

        // Glyph 0101_0000
        mem[0] = 8'h41; rom_data = 8'b0101_0000;
        want = '{default: 12'h000};
        want[1] = 12'hFFF; want[3] = 12'hFFF;
        scan(10'd0, 10'd0, 8, "glyph50");

        // Blanking forces black even with a full glyph row
        rom_data = 8'hFF; pixel_x = 10'd3; video_on = 1'b0;
        step(); step(); step();
        chk("blank_rgb", 32'(rgb), 32'h000);
        chk("blank_von", 32'(video_on_out), 32'd0);
        video_on = 1'b1;
        step(); step(); step();
        chk("active_rgb", 32'(rgb), 32'hFFF);
        chk("active_von", 32'(video_on_out), 32'd1);

        // Sync delay: hsync low for cycles 2-3, vsync low for cycle 5
        for (int i = 0; i < 10; i++) begin
            hsync_in = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            vsync_in = (i == 5) ? 1'b0 : 1'b1;
            step();
            if (i >= 2) begin
                chk($sformatf("hs_dly[%0d]", i - 2), 32'(hsync_out),
                    (i - 2 == 2 || i - 2 == 3) ? 32'd0 : 32'd1);
                chk($sformatf("vs_dly[%0d]", i - 2), 32'(vsync_out),
                    (i - 2 == 5) ? 32'd0 : 32'd1);
            end
        end

        // Asynchronous reset mid-line
        rom_data = 8'hFF; pixel_x = 10'd5; video_on = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        step(); step(); step();
        chk("pre_rst_rgb", 32'(rgb), 32'hFFF);
        chk("pre_rst_hs",  32'(hsync_out), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_rgb", 32'(rgb), 32'h000);
        chk("arst_hs",  32'(hsync_out), 32'd1);
        chk("arst_vs",  32'(vsync_out), 32'd1);
        chk("arst_von", 32'(video_on_out), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("rel1_rgb", 32'(rgb), 32'h000);
        chk("rel1_hs",  32'(hsync_out), 32'd1);
        step();
        chk("rel2_rgb", 32'(rgb), 32'h000);
        chk("rel2_von", 32'(video_on_out), 32'd0);
        step();
        chk("rel3_rgb", 32'(rgb), 32'hFFF);
        chk("rel3_hs",  32'(hsync_out), 32'd0);
        chk("rel3_von", 32'(video_on_out), 32'd1);

        // Cursor at (1,0): blinks with BLINK_FRAMES=2 only when the feature is built
        hsync_in = 1'b1; vsync_in = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem[0] = 8'h20; mem[1] = 8'h20; rom_data = 8'h00;
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 16; p++)
                want[p] = (c_BLINK_BUILD && p >= 8 && (f == 2 || f == 3)) ? 12'hFFF : 12'h000;
            scan(10'd0, 10'd0, 16, $sformatf("cursor_f%0d", f));
            vsync_in = 1'b0;
            step();
            vsync_in = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_text_pixel_gen
`default_nettype wire
